// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// the reset NOP encoding and instruction field positions.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_MSB   = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7_BIT30 = 30;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register for the fetch unit: reset load, word-aligned
// redirect (highest priority) and sequential +4 increment.
module fetch_pc_reg #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_en_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ALIGN_MASK;
        end else if (inc_en_i) begin
            pc_d = pc_q + PC_STEP;  // wraps naturally at 2^PC_W
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD handshake between instruction memory
// and the control stage. Define FETCH_ICOUNT_EN to add the icount output.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      Opcode,
    output logic [3:0]      Funct,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc_out
`ifdef FETCH_ICOUNT_EN
    ,
    output logic [63:0]     icount
`endif
);

    fetch_state_e    state_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_out_q;
    logic            imem_req_q;
    logic            out_valid_q;
    logic [PC_W-1:0] pc;
    logic            pc_inc;

    // Only a response that is not overridden by a redirect advances the PC.
    assign pc_inc = (state_q == FETCH) && imem_ready && !redirect_valid;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .inc_en_i      (pc_inc),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= '0;
            imem_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            state_q     <= FETCH;
            imem_req_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q     <= imem_rdata;
                        pc_out_q    <= pc;
                        state_q     <= HOLD;
                        imem_req_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= FETCH;
                        imem_req_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    imem_req_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [63:0] icount_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icount_q <= '0;
        end else if ((state_q == HOLD) && out_ready && !redirect_valid) begin
            icount_q <= icount_q + 64'd1;
        end
    end

    assign icount = icount_q;
`endif

    assign imem_req  = imem_req_q;
    assign imem_addr = pc;
    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign pc_out    = pc_out_q;
    assign Opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign Funct     = {instr_q[FUNCT7_BIT30], instr_q[FUNCT3_MSB:FUNCT3_LSB]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural fetch model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_instr_fetch_unit;

    localparam int          PC_W  = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
    logic [31:0] instr;
    logic [63:0] pc_out;
`ifdef FETCH_ICOUNT_EN
    logic [63:0] icount;
`endif

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .Opcode         (Opcode),
        .Funct          (Funct),
        .instr          (instr),
        .pc_out         (pc_out)
`ifdef FETCH_ICOUNT_EN
        ,
        .icount         (icount)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural model: phase 0 = not yet fetching, 1 = waiting on memory,
    // 2 = presenting an instruction to the control stage.
    int          m_phase  = 0;
    logic [63:0] m_pc     = RST_PC;
    logic [63:0] m_pc_out = 64'h0;
    logic [31:0] m_instr  = 32'h00000013;
    logic [63:0] m_icount = 64'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  = 0;
            m_pc     = RST_PC;
            m_pc_out = 64'h0;
            m_instr  = 32'h00000013;
            m_icount = 64'h0;
        end else if (redirect_valid) begin
            m_pc    = redirect_pc - (redirect_pc % 4);
            m_phase = 1;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 && imem_ready) begin
            m_instr  = imem_rdata;
            m_pc_out = m_pc;
            m_pc     = m_pc + 64'd4;
            m_phase  = 2;
        end else if (m_phase == 2 && out_ready) begin
            m_phase  = 1;
            m_icount = m_icount + 64'd1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_req",  {63'd0, imem_req},  {63'd0, m_phase == 1});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
            chk("imem_addr", imem_addr, m_pc);
            chk("instr",     {32'd0, instr}, {32'd0, m_instr});
            chk("pc_out",    pc_out, m_pc_out);
            chk("Opcode",    {57'd0, Opcode}, 64'(m_instr % 128));
            chk("Funct",     {60'd0, Funct},
                64'(((m_instr >> 30) % 2) * 8 + ((m_instr >> 12) % 8)));
`ifdef FETCH_ICOUNT_EN
            chk("icount",    icount, m_icount);
`endif
            if (out_valid && out_ready && !redirect_valid)
                $display("txn pc=%h instr=%h opcode=%b funct=%b", pc_out, instr, Opcode, Funct);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_imem_req",  {63'd0, imem_req},  64'd0);
        chk("rst_imem_addr", imem_addr, 64'h100);
        chk("rst_instr",     {32'd0, instr}, 64'h13);
        chk("rst_pc_out",    pc_out, 64'h0);
        tick(2);
        check_en = 1'b1;

        // Zero-wait add, first out_valid on the third cycle after release
        imem_ready = 1'b1; imem_rdata = 32'h00B50533; out_ready = 1'b1; reset = 1'b0;
        tick(1);
        chk("t1_c2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_c2_imem_req",  {63'd0, imem_req},  64'd1);
        tick(1);
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_opcode",    {57'd0, Opcode}, 64'b0110011);
        chk("t1_funct",     {60'd0, Funct},  64'b0000);
        chk("t1_pc_out",    pc_out, 64'h100);
        chk("t1_next_addr", imem_addr, 64'h104);

        // sub held by back-pressure for 5 cycles
        tick(1);
        out_ready = 1'b0; imem_rdata = 32'h40B50533;
        tick(1);
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
            chk("t2_funct",     {60'd0, Funct}, 64'b1000);
            chk("t2_imem_req",  {63'd0, imem_req}, 64'd0);
            tick(1);
        end

        // Memory answers after a 3-cycle wait
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t3_imem_req",  {63'd0, imem_req}, 64'd1);
            chk("t3_imem_addr", imem_addr, 64'h108);
        end
        imem_ready = 1'b1; imem_rdata = 32'h00100093;
        tick(1);
        chk("t3_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t3_pc_out",    pc_out, 64'h108);

        // Redirect coincident with a memory response drops it
        out_ready = 1'b1; imem_ready = 1'b0;
        tick(1);
        imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        redirect_valid = 1'b1; redirect_pc = 64'h203;
        tick(1);
        chk("t4_imem_addr", imem_addr, 64'h200);
        chk("t4_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_instr",     {32'd0, instr}, 64'h00100093);
        chk("t4_pc_out",    pc_out, 64'h108);

        // lw / sw / beq sequence
        redirect_valid = 1'b0; imem_rdata = 32'h0002A303;
        tick(1);
        chk("t5_lw_opcode", {57'd0, Opcode}, 64'b0000011);
        chk("t5_lw_funct",  {60'd0, Funct},  64'b0010);
        chk("t5_lw_pc",     pc_out, 64'h200);
        tick(1);
        imem_rdata = 32'h0062A023;
        tick(1);
        chk("t5_sw_opcode", {57'd0, Opcode}, 64'b0100011);
        chk("t5_sw_funct",  {60'd0, Funct},  64'b0010);
        chk("t5_sw_pc",     pc_out, 64'h204);
        tick(1);
        imem_rdata = 32'h00628463;
        tick(1);
        chk("t5_beq_opcode", {57'd0, Opcode}, 64'b1100011);
        chk("t5_beq_funct",  {60'd0, Funct},  64'b0000);
        chk("t5_beq_pc",     pc_out, 64'h208);

        // Redirect with out_ready in HOLD, then PC wrap past 2^64
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick(1);
        chk("t6_imem_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef FETCH_ICOUNT_EN
        chk("t6_icount", icount, 64'd5);
`endif
        redirect_valid = 1'b0; out_ready = 1'b0; imem_rdata = 32'h00100093;
        tick(1);
        chk("t6_pc_out",    pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_wrap_addr", imem_addr, 64'h0);

        // Reset in the middle of a fetch, then a late ready after release
        out_ready = 1'b1; imem_ready = 1'b0;
        tick(1);
        #3 reset = 1'b1;
        #1;
        chk("t7_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t7_imem_req",  {63'd0, imem_req},  64'd0);
        chk("t7_imem_addr", imem_addr, 64'h100);
        chk("t7_pc_out",    pc_out, 64'h0);
`ifdef FETCH_ICOUNT_EN
        chk("t7_icount", icount, 64'd0);
`endif
        @(posedge clk);
        #1;
        imem_ready = 1'b1; imem_rdata = 32'h00B50533; reset = 1'b0;
        tick(1);
        chk("t7_late_ready_ignored", {63'd0, out_valid}, 64'd0);
        tick(1);
        chk("t7_refetch_valid", {63'd0, out_valid}, 64'd1);
        chk("t7_refetch_pc",    pc_out, 64'h100);
        tick(1);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
